// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, redirect input and decode handoff.
// The master side is the fetch stage; the slave side is the memory/decode environment.
interface instr_fetch_if;
  logic [15:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [15:0] id_pc;

  modport master (
    output imem_pc, id_valid, id_instr, id_pc,
    input  imem_instr, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_pc, id_valid, id_instr, id_pc,
    output imem_instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC generation against a 1-cycle synchronous imem,
// 2-entry {pc,instr} buffer toward decode, and full flush on control-flow redirect.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [15:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [15:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];

  logic       pop;
  logic       land;
  logic       issue;
  logic       wr_idx;
  logic [1:0] count_after_pop;
  logic [1:0] count_land;

  always_comb begin
    pop             = (count_q != 2'd0) & bus.id_ready;
    land            = inflight_q & ~bus.redirect_valid;
    count_after_pop = count_q - {1'b0, pop};
    count_land      = count_after_pop + {1'b0, land};
    // Tail slot is head+count; with a full buffer it reuses the slot being popped.
    wr_idx          = head_q ^ count_q[0];
    issue           = 1'b0;

    fetch_pc_d      = fetch_pc_q;
    inflight_d      = 1'b0;
    inflight_pc_d   = inflight_pc_q;
    count_d         = count_land;
    head_d          = head_q ^ pop;

    if (bus.redirect_valid) begin
      count_d    = 2'd0;
      fetch_pc_d = bus.redirect_pc & 16'hFFFC;
    end else begin
      issue = (count_land < 2'd2);
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 16'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
    end
  end

  // Buffer storage is reset so the decode-facing outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_pc_q[0]    <= 16'h0000;
      fifo_pc_q[1]    <= 16'h0000;
      fifo_instr_q[0] <= 32'h0000_0000;
      fifo_instr_q[1] <= 32'h0000_0000;
    end else if (land) begin
      fifo_pc_q[wr_idx]    <= inflight_pc_q;
      fifo_instr_q[wr_idx] <= bus.imem_instr;
    end
  end

  assign bus.imem_pc  = fetch_pc_q;
  assign bus.id_valid = (count_q != 2'd0);
  assign bus.id_instr = fifo_instr_q[head_q];
  assign bus.id_pc    = fifo_pc_q[head_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, streaming, back-pressure, redirects,
// PC wrap-around (second instance with RESET_PC=FFF8) and asynchronous reset.
module tb_instr_fetch;
  logic clk;
  logic rst_n;
  logic rst2_n;
  int   passed;
  int   total;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_fetch #(.RESET_PC(16'hFFF8)) u_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model: mem[i] = A000_0000 + i, word-indexed.
  always @(posedge clk) begin
    bus.imem_instr  <= 32'hA000_0000 + {18'd0, bus.imem_pc[15:2]};
    bus2.imem_instr <= 32'hA000_0000 + {18'd0, bus2.imem_pc[15:2]};
  end

  task automatic reset_dut(input logic ready);
    rst_n              = 1'b0;
    bus.id_ready       = ready;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (bus.id_valid !== 1'b0) $display("FAIL reset_id_valid got %0h want 0", bus.id_valid); else passed++;
    total++; if (bus.id_pc !== 16'h0000) $display("FAIL reset_id_pc got %h want 0000", bus.id_pc); else passed++;
    total++; if (bus.id_instr !== 32'h0) $display("FAIL reset_id_instr got %h want 00000000", bus.id_instr); else passed++;
    total++; if (bus.imem_pc !== 16'h0000) $display("FAIL reset_imem_pc got %h want 0000", bus.imem_pc); else passed++;
  endtask

  task automatic test_stream;
    logic [15:0] e_pc;
    logic [31:0] e_in;
    reset_dut(1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++; if (bus.id_valid !== 1'b0) $display("FAIL stream_latency id_valid got %0h want 0", bus.id_valid); else passed++;
      end else begin
        e_pc = 16'((c - 1) * 4);
        e_in = 32'hA000_0000 + 32'(c - 1);
        total++; if (bus.id_valid !== 1'b1) $display("FAIL stream_valid c=%0d got %0h want 1", c, bus.id_valid); else passed++;
        total++; if (bus.id_pc !== e_pc) $display("FAIL stream_pc c=%0d got %h want %h", c, bus.id_pc, e_pc); else passed++;
        total++; if (bus.id_instr !== e_in) $display("FAIL stream_instr c=%0d got %h want %h", c, bus.id_instr, e_in); else passed++;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] e_pc;
    reset_dut(1'b0);
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.id_pc !== 16'h0000 || bus.id_valid !== 1'b1) $display("FAIL bp_first got v=%0h pc=%h want v=1 pc=0000", bus.id_valid, bus.id_pc); else passed++;
    for (int c = 0; c < 5; c++) @(negedge clk);
    total++; if (bus.imem_pc !== 16'h0008) $display("FAIL bp_imem_pc_frozen got %h want 0008", bus.imem_pc); else passed++;
    total++; if (bus.id_pc !== 16'h0000 || bus.id_valid !== 1'b1) $display("FAIL bp_head_held got v=%0h pc=%h want v=1 pc=0000", bus.id_valid, bus.id_pc); else passed++;
    bus.id_ready = 1'b1;
    e_pc = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      total++; if (bus.id_valid !== 1'b1) $display("FAIL bp_resume_valid c=%0d got %0h want 1", c, bus.id_valid); else passed++;
      total++; if (bus.id_pc !== e_pc) $display("FAIL bp_resume_pc c=%0d got %h want %h", c, bus.id_pc, e_pc); else passed++;
      total++; if (bus.id_instr !== 32'hA000_0000 + {18'd0, e_pc[15:2]}) $display("FAIL bp_resume_instr c=%0d got %h want %h", c, bus.id_instr, 32'hA000_0000 + {18'd0, e_pc[15:2]}); else passed++;
      @(negedge clk);
      e_pc = e_pc + 16'd4;
    end
  endtask

  task automatic test_redirect;
    reset_dut(1'b1);
    for (int c = 0; c < 4; c++) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0103;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    total++; if (bus.id_valid !== 1'b0) $display("FAIL redir_flush got %0h want 0", bus.id_valid); else passed++;
    @(negedge clk);
    total++; if (bus.id_valid !== 1'b0) $display("FAIL redir_gap got %0h want 0", bus.id_valid); else passed++;
    @(negedge clk);
    total++; if (bus.id_valid !== 1'b1) $display("FAIL redir_valid got %0h want 1", bus.id_valid); else passed++;
    total++; if (bus.id_pc !== 16'h0100) $display("FAIL redir_pc got %h want 0100", bus.id_pc); else passed++;
    total++; if (bus.id_instr !== 32'hA000_0040) $display("FAIL redir_instr got %h want a0000040", bus.id_instr); else passed++;
    @(negedge clk);
    total++; if (bus.id_pc !== 16'h0104) $display("FAIL redir_next_pc got %h want 0104", bus.id_pc); else passed++;
    total++; if (bus.id_instr !== 32'hA000_0041) $display("FAIL redir_next_instr got %h want a0000041", bus.id_instr); else passed++;
  endtask

  task automatic test_redirect_full;
    reset_dut(1'b0);
    for (int c = 0; c < 6; c++) @(negedge clk);
    total++; if (bus.id_pc !== 16'h0000 || bus.id_valid !== 1'b1) $display("FAIL rfull_pre got v=%0h pc=%h want v=1 pc=0000", bus.id_valid, bus.id_pc); else passed++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    total++; if (bus.id_valid !== 1'b0) $display("FAIL rfull_flush got %0h want 0", bus.id_valid); else passed++;
    bus.id_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.id_valid !== 1'b0) $display("FAIL rfull_gap got %0h want 0", bus.id_valid); else passed++;
    @(negedge clk);
    total++; if (bus.id_valid !== 1'b1) $display("FAIL rfull_valid got %0h want 1", bus.id_valid); else passed++;
    total++; if (bus.id_pc !== 16'h0200) $display("FAIL rfull_pc got %h want 0200", bus.id_pc); else passed++;
    total++; if (bus.id_instr !== 32'hA000_0080) $display("FAIL rfull_instr got %h want a0000080", bus.id_instr); else passed++;
  endtask

  task automatic test_wrap;
    logic [15:0] e_pc;
    rst2_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    total++; if (bus2.id_valid !== 1'b0) $display("FAIL wrap_latency got %0h want 0", bus2.id_valid); else passed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e_pc = 16'hFFF8 + 16'(k * 4);
      total++; if (bus2.id_valid !== 1'b1 || bus2.id_pc !== e_pc) $display("FAIL wrap_pc k=%0d got v=%0h pc=%h want v=1 pc=%h", k, bus2.id_valid, bus2.id_pc, e_pc); else passed++;
      total++; if (bus2.id_instr !== 32'hA000_0000 + {18'd0, e_pc[15:2]}) $display("FAIL wrap_instr k=%0d got %h want %h", k, bus2.id_instr, 32'hA000_0000 + {18'd0, e_pc[15:2]}); else passed++;
    end
  endtask

  task automatic test_async_reset;
    reset_dut(1'b1);
    for (int c = 0; c < 4; c++) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.id_valid !== 1'b0) $display("FAIL areset_valid got %0h want 0", bus.id_valid); else passed++;
    total++; if (bus.id_pc !== 16'h0000) $display("FAIL areset_pc got %h want 0000", bus.id_pc); else passed++;
    total++; if (bus.id_instr !== 32'h0) $display("FAIL areset_instr got %h want 00000000", bus.id_instr); else passed++;
    total++; if (bus.imem_pc !== 16'h0000) $display("FAIL areset_imem_pc got %h want 0000", bus.imem_pc); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.id_valid !== 1'b0) $display("FAIL areset_latency got %0h want 0", bus.id_valid); else passed++;
    @(negedge clk);
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 16'h0000) $display("FAIL areset_restart_pc got v=%0h pc=%h want v=1 pc=0000", bus.id_valid, bus.id_pc); else passed++;
    total++; if (bus.id_instr !== 32'hA000_0000) $display("FAIL areset_restart_instr got %h want a0000000", bus.id_instr); else passed++;
  endtask

  initial begin
    passed              = 0;
    total               = 0;
    rst_n               = 1'b1;
    rst2_n              = 1'b0;
    bus.id_ready        = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 16'h0000;
    bus2.id_ready       = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 16'h0000;
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage feeding the synchronous-read instruction memory and handing fetched words to decode. Generates the fetch PC, tracks the one-cycle memory read latency, buffers returned instructions in a 2-entry FIFO so decode back-pressure never loses a word, and handles control-flow redirects by flushing all in-flight and buffered fetches.

## Interface
- RESET_PC, 16'h0000, first fetch address after reset (word aligned)
- clk  in  1  rising-edge clock shared with the instruction memory
- rst_n  in  1  asynchronous, active-low reset
- imem_pc  out  16  byte address to instruction memory; equals internal fetch_pc (combinational from register)
- imem_instr  in  32  memory read data; word for the address presented in the previous cycle
- redirect_valid  in  1  branch/jump taken; overrides sequential fetch
- redirect_pc  in  16  redirect target; bits [1:0] ignored (forced 0)
- id_valid  out  1  FIFO head holds a valid instruction
- id_ready  in  1  decode accepts head this cycle
- id_instr  out  32  instruction at FIFO head
- id_pc  out  16  byte address of id_instr

## Operation
- State: fetch_pc[15:0], inflight (1b), inflight_pc[15:0], FIFO of 2 {pc,instr} entries, count 0..2.
- pop = id_valid & id_ready. land = inflight & !redirect_valid.
- count_next = count - pop + land; landing word written at tail = {inflight_pc, imem_instr}.
- issue = !redirect_valid & (count_next < 2). On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^16, 16'hFFFC wraps to 16'h0000). Otherwise inflight<=0, fetch_pc holds.
- Memory reads every cycle regardless; data for non-issue cycles is ignored.
- Redirect (priority over everything): FIFO count<=0, inflight<=0, fetch_pc<={redirect_pc[15:2],2'b00}, no issue that cycle. A pop in the redirect cycle still completes (decode owns that word); the landing word that cycle is discarded.
- id_instr/id_pc reflect FIFO head; values are don't-care-stable (hold last head) when id_valid=0.
- FIFO never overflows: issue gating guarantees count+inflight <= 2.

## Timing
- Reset (async assert, any time): fetch_pc=RESET_PC, inflight=0, count=0; outputs id_valid=0, id_instr=0, id_pc=0, imem_pc=RESET_PC. Mid-operation reset discards all in-flight and buffered words.
- Edge E1 = first rising edge with rst_n high: issues RESET_PC. E2: word lands in FIFO. id_valid=1 after E2 (2-cycle fetch-to-decode latency).
- Steady state with id_ready=1: one instruction per cycle, PCs consecutive +4.
- id_ready=0: FIFO fills to 2, issue stops; imem_pc holds at next unfetched address. On id_ready returning to 1, head pops that cycle, fetch resumes the same cycle; no bubble visible at id_valid while FIFO is non-empty.
- Redirect at edge Er: id_valid=0 after Er; first target word visible after Er+2. No word fetched before the redirect appears after it.
- Simultaneous redirect and id_ready=0 with full FIFO: flush still occurs.

## Test plan
- Reset release, memory model mem[i]=32'hA000_0000+i, id_ready=1 -> id_valid rises after E2; id_pc 0,4,8,12... with id_instr A0000000,A0000001,... one per cycle, no gaps.
- Hold id_ready=0 for 5 cycles after first word, then 1 -> count saturates at 2, imem_pc frozen at 16'h0008; released stream continues 0,4,8,12 with no duplicate or dropped PC.
- redirect_valid=1, redirect_pc=16'h0103 mid-stream -> id_valid=0 next cycle; 2 cycles later id_pc=16'h0100, id_instr=mem[64]; no older PC appears after redirect.
- Redirect while FIFO full and id_ready=0 -> FIFO flushed, next delivered id_pc=target.
- RESET_PC=16'hFFF8 -> id_pc sequence FFF8, FFFC, 0000, 0004.
- Assert rst_n=0 asynchronously mid-stream -> id_valid, id_pc, id_instr go 0 immediately; after release fetch restarts at RESET_PC.
